// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter. Shifts one DBIT-wide word out LSB first,
// framed by a start bit and a stop period. Bit timing comes from an external
// oversample tick (16 ticks per bit). syn_clr gives a synchronous abort to
// IDLE. The tx pin is driven straight from a flop so it is glitch-free.
module uart_tx_frame #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            syn_clr,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            tx
);

  // The tick counter must reach both 15 (one bit time) and SB_TICK-1 (stop period).
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = $clog2(DBIT);

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(32'd15);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 32'd1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          r_state, w_state_next;
  logic [SW-1:0]   r_s, w_s_next;
  logic [NW-1:0]   r_n, w_n_next;
  logic [DBIT-1:0] r_b, w_b_next;
  logic            r_tx, w_tx_next;
  logic            r_busy;
  logic            r_done, w_done_next;

  // Next-state logic; the abort overrides everything else.
  always_comb begin
    w_state_next = r_state;
    w_s_next     = r_s;
    w_n_next     = r_n;
    w_b_next     = r_b;
    w_done_next  = 1'b0;
    if (syn_clr) begin
      w_state_next = IDLE;
      w_s_next     = '0;
      w_n_next     = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (tx_start) begin
            w_b_next     = din;
            w_s_next     = '0;
            w_state_next = START;
          end else begin
            w_state_next = IDLE;
          end
        end
        START: begin
          if (s_tick) begin
            if (r_s == S_BIT_LAST) begin
              w_s_next     = '0;
              w_n_next     = '0;
              w_state_next = DATA;
            end else begin
              w_s_next = r_s + 1'b1;
            end
          end else begin
            w_s_next = r_s;
          end
        end
        DATA: begin
          if (s_tick) begin
            if (r_s == S_BIT_LAST) begin
              w_s_next = '0;
              w_b_next = r_b >> 1;
              if (r_n == N_LAST) begin
                w_state_next = STOP;
              end else begin
                w_n_next = r_n + 1'b1;
              end
            end else begin
              w_s_next = r_s + 1'b1;
            end
          end else begin
            w_s_next = r_s;
          end
        end
        STOP: begin
          if (s_tick) begin
            if (r_s == S_STOP_LAST) begin
              w_state_next = IDLE;
              w_done_next  = 1'b1;
            end else begin
              w_s_next = r_s + 1'b1;
            end
          end else begin
            w_s_next = r_s;
          end
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  // Line level follows the state being entered, so the pin moves on the same edge as the state.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      IDLE:    w_tx_next = 1'b1;
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_b_next[0];
      STOP:    w_tx_next = 1'b1;
      default: w_tx_next = 1'b1;
    endcase
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_s     <= w_s_next;
      r_n     <= w_n_next;
      r_b     <= w_b_next;
      r_tx    <= w_tx_next;
      r_busy  <= (w_state_next != IDLE);
      r_done  <= w_done_next;
    end
  end

  assign tx           = r_tx;
  assign tx_busy      = r_busy;
  assign tx_done_tick = r_done;

endmodule
